// File: rtl/conv_encoder_tx.sv
// rtl/conv_encoder_tx.sv - rate-1/2 K=3 convolutional encoder with serial frame output
//
// Purpose:
//   Encodes one DATA_BITS-wide info word per frame with generators g0=111 and g1=101,
//   appends TAIL_BITS zero flush bits so the trellis ends in state 00, and serialises
//   FRAME_BITS code bits on singlecode, one per clk1 edge. For each info bit, c0 goes out
//   first on an even count and c1 follows on an odd count. A load accepted on the last
//   code bit starts the next frame on the following edge, so frames run without a gap.
//
// Ports:
//   clk1        in   bit clock, one code bit per rising edge
//   reset       in   asynchronous active-low reset
//   valid       in   link enable; low clears everything synchronously
//   data_in     in   info word, MSB encoded first
//   data_load   in   load request, taken only while data_ready is high
//   data_ready  out  combinational; high in IDLE or on the last code bit of a frame
//   singlecode  out  registered serial code bit
//   code_valid  out  high while singlecode carries frame bits
//   frame_start out  high during the first code bit of each frame

module conv_encoder_tx #(
    parameter  int DATA_BITS  = 5,
    parameter  int TAIL_BITS  = 2,
    localparam int FRAME_BITS = 2 * (DATA_BITS + TAIL_BITS)
) (
    input  logic                 clk1,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_load,
    output logic                 data_ready,
    output logic                 singlecode,
    output logic                 code_valid,
    output logic                 frame_start
);

    localparam int INFO_W = DATA_BITS + TAIL_BITS;
    localparam int CNT_W  = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         s_q, s_d;
    logic [INFO_W-1:0]  info_q, info_d;
    logic               singlecode_q, singlecode_d;
    logic               code_valid_q, code_valid_d;
    logic               frame_start_q, frame_start_d;

    logic               last_bit;
    logic               load_ok;
    logic               u_d;

    assign last_bit   = (cnt_q == LAST_CNT);
    assign data_ready = ((state_q == IDLE) | last_bit) & valid & reset;
    assign load_ok    = data_load & data_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        info_d  = info_q;

        if (!valid) begin
            state_d = IDLE;
            cnt_d   = '0;
            s_d     = 2'b00;
            info_d  = '0;
        end else if (load_ok) begin
            state_d = SEND;
            cnt_d   = '0;
            s_d     = 2'b00;
            info_d  = {data_in, {TAIL_BITS{1'b0}}};
        end else if (state_q == SEND) begin
            if (last_bit) begin
                state_d = IDLE;
                cnt_d   = '0;
                s_d     = 2'b00;
                info_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                // c1 of the current info bit has just been sent: advance the trellis
                if (cnt_q[0]) begin
                    s_d    = {info_q[INFO_W-1], s_q[1]};
                    info_d = {info_q[INFO_W-2:0], 1'b0};
                end
            end
        end

        // The output is registered, so the bit shown after this edge is encoded
        // from the next-state values.
        u_d = info_d[INFO_W-1];
        if (cnt_d[0]) begin
            singlecode_d = (state_d == SEND) & (u_d ^ s_d[0]);
        end else begin
            singlecode_d = (state_d == SEND) & (u_d ^ s_d[1] ^ s_d[0]);
        end
        code_valid_d  = (state_d == SEND);
        frame_start_d = (state_d == SEND) && (cnt_d == '0);
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            s_q           <= 2'b00;
            info_q        <= '0;
            singlecode_q  <= 1'b0;
            code_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            s_q           <= s_d;
            info_q        <= info_d;
            singlecode_q  <= singlecode_d;
            code_valid_q  <= code_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign singlecode  = singlecode_q;
    assign code_valid  = code_valid_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb/tb_conv_encoder_tx.sv - self-checking bench for conv_encoder_tx

module tb_conv_encoder_tx;

    logic       clk1;
    logic       reset;
    logic       valid;
    logic [4:0] data_in;
    logic       data_load;
    logic       data_ready;
    logic       singlecode;
    logic       code_valid;
    logic       frame_start;

    conv_encoder_tx dut (
        .clk1        (clk1),
        .reset       (reset),
        .valid       (valid),
        .data_in     (data_in),
        .data_load   (data_load),
        .data_ready  (data_ready),
        .singlecode  (singlecode),
        .code_valid  (code_valid),
        .frame_start (frame_start)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: the frame being shown and the index of the visible bit
    logic [13:0] m_frame;
    int          m_pos;
    logic        m_active;
    logic [13:0] cap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Encodes word+tail with plain modulo-2 sums; r[k] is code bit k.
    function automatic logic [13:0] encode(input logic [4:0] w);
        int p1;
        int p2;
        int u;
        logic [13:0] r;
        p1 = 0;
        p2 = 0;
        r  = '0;
        for (int i = 0; i < 7; i++) begin
            u = (i < 5) ? ((int'(w) >> (4 - i)) & 1) : 0;
            r[2*i]   = ((u + p1 + p2) % 2) != 0;
            r[2*i+1] = ((u + p2) % 2) != 0;
            p2 = p1;
            p1 = u;
        end
        return r;
    endfunction

    function automatic logic model_ready(input logic v);
        return v && reset && (!m_active || m_pos == 13);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".code_valid"},  code_valid,  m_active);
        check({tag, ".singlecode"},  singlecode,  m_active ? m_frame[m_pos] : 1'b0);
        check({tag, ".frame_start"}, frame_start, m_active && m_pos == 0);
    endtask

    // Called at a negedge: apply inputs, cross an edge, update model, check.
    task automatic cycle(input logic v, input logic ld, input logic [4:0] din);
        logic acc;
        valid     = v;
        data_load = ld;
        data_in   = din;
        #1;
        check("data_ready", data_ready, model_ready(v));
        acc = ld && model_ready(v);
        @(posedge clk1);
        if (!v) begin
            m_active = 1'b0;
        end else if (acc) begin
            m_frame  = encode(din);
            m_pos    = 0;
            m_active = 1'b1;
        end else if (m_active) begin
            if (m_pos == 13) m_active = 1'b0;
            else             m_pos++;
        end
        @(negedge clk1);
        check_outputs("cyc");
        cap = {cap[12:0], singlecode};
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 5'($urandom));
    endtask

    initial begin
        m_active  = 1'b0;
        m_pos     = 0;
        m_frame   = '0;
        cap       = '0;
        reset     = 1'b0;
        valid     = 1'b0;
        data_load = 1'b0;
        data_in   = '0;

        // reset state
        repeat (2) @(negedge clk1);
        check("rst.singlecode",  singlecode,  1'b0);
        check("rst.code_valid",  code_valid,  1'b0);
        check("rst.frame_start", frame_start, 1'b0);
        check("rst.data_ready",  data_ready,  1'b0);
        reset = 1'b1;
        valid = 1'b1;
        #1;
        check("rst.ready_after", data_ready, 1'b1);
        @(negedge clk1);

        // single frames against known code sequences
        cycle(1'b1, 1'b1, 5'b10110); plain(13);
        check("t2.bits", cap, 14'b11100001011100);
        plain(2);
        cycle(1'b1, 1'b1, 5'b11111); plain(13);
        check("t3.bits_11111", cap, 14'b11011010100111);
        plain(1);
        cycle(1'b1, 1'b1, 5'b00000); plain(13);
        check("t3.bits_00000", cap, 14'b0);
        plain(1);

        // back-to-back frames; a load while busy must be ignored
        cycle(1'b1, 1'b1, 5'b10110); plain(5);
        cycle(1'b1, 1'b1, 5'b01010); plain(7);
        check("t4.bits_a", cap, 14'b11100001011100);
        cycle(1'b1, 1'b1, 5'b11111); plain(13);
        check("t4.bits_b", cap, 14'b11011010100111);
        plain(1);

        // valid dropped at cnt=6
        cycle(1'b1, 1'b1, 5'b10110); plain(6);
        cycle(1'b0, 1'b0, 5'b0);
        cycle(1'b1, 1'b1, 5'b10110); plain(13);
        check("t5.valid_bits", cap, 14'b11100001011100);

        // async reset at cnt=6
        cycle(1'b1, 1'b1, 5'b10110); plain(6);
        reset = 1'b0;
        #1;
        m_active = 1'b0;
        check("t5.arst_code_valid", code_valid, 1'b0);
        check("t5.arst_singlecode", singlecode, 1'b0);
        check("t5.arst_ready",      data_ready, 1'b0);
        @(negedge clk1);
        reset = 1'b1;
        cycle(1'b1, 1'b1, 5'b10110); plain(13);
        check("t5.arst_bits", cap, 14'b11100001011100);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 25) != 0, ($urandom % 3) == 0, 5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
